// File: rtl/startup_sequencer.sv
// -----------------------------------------------------------------------------
// startup_sequencer
//
// Ordered power-up sequencer for up to 16 dependent stages (PLLs, PHYs, codecs).
// After a fixed INIT delay each stage is enabled in turn. A stage must
// acknowledge within TIMEOUT cycles. It then gets SETTLE_TIME cycles before the
// next stage is enabled. Once every stage is up, the block supervises the
// acknowledges, and any dropped acknowledge shuts everything down.
//
// Optional feature macro: STARTUP_SEQ_RETRY_EN
//   When this macro is defined, a WAIT timeout first power-cycles the stage
//   (RETRY_OFF for SETTLE_TIME cycles), up to MAX_RETRIES times, before the
//   block faults. When it is undefined, a timeout faults immediately.
//
// Ports:
//   clock        in   1       single clock
//   reset_n      in   1       asynchronous active-low reset
//   restart      in   1       synchronous request to rerun from INIT
//   stage_done   in   STAGES  per-stage acknowledge (already synchronous)
//   stage_en     out  STAGES  cumulative per-stage enable
//   busy         out  1       INIT / WAIT / SETTLE / RETRY_OFF
//   started      out  1       all stages up (DONE)
//   fault        out  1       FAULT state
//   fault_stage  out  4       stage that caused the fault (valid with fault)
// -----------------------------------------------------------------------------
module startup_sequencer #(
   parameter int unsigned STAGES      = 4,
   parameter logic [31:0] INIT_TIME   = 32'd100000000,
   parameter logic [31:0] SETTLE_TIME = 32'd1000,
   parameter logic [31:0] TIMEOUT     = 32'd2000000,
   parameter int unsigned MAX_RETRIES = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              restart,
   input  logic [STAGES-1:0] stage_done,
   output logic [STAGES-1:0] stage_en,
   output logic              busy,
   output logic              started,
   output logic              fault,
   output logic [3:0]        fault_stage
);

   typedef enum logic [2:0] {
      S_INIT,
      S_WAIT,
      S_SETTLE,
      S_DONE,
      S_FAULT
`ifdef STARTUP_SEQ_RETRY_EN
      , S_RETRY_OFF
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       count_q, count_d;
   logic [3:0]        idx_q, idx_d;
   logic [STAGES-1:0] en_q, en_d;
   logic              busy_q, busy_d;
   logic              started_q, started_d;
   logic              fault_q, fault_d;
   logic [3:0]        fs_q, fs_d;
`ifdef STARTUP_SEQ_RETRY_EN
   logic [3:0]        retry_q, retry_d;
`else
   logic              unused_cfg;
   assign unused_cfg = (MAX_RETRIES > 32'd15);
`endif

   // Decoded views of idx_q plus the loss-of-acknowledge detector.
   logic [STAGES-1:0] idx_oh;
   logic [STAGES-1:0] next_oh;
   logic [STAGES-1:0] chk_mask;
   logic              ack;
   logic              lost_any;
   logic [3:0]        lost_idx;

   always_comb begin
      idx_oh   = '0;
      next_oh  = '0;
      chk_mask = '0;
      lost_any = 1'b0;
      lost_idx = '0;
      for (int unsigned j = 0; j < STAGES; j++) begin
         if (4'(j) == idx_q)        idx_oh[j]  = 1'b1;
         if (4'(j) == idx_q + 4'd1) next_oh[j] = 1'b1;
         // Stages below idx are already up and must stay acknowledged.
         // SETTLE also covers idx itself, and DONE covers every stage.
         if (state_q == S_DONE)
            chk_mask[j] = 1'b1;
         else if (4'(j) < idx_q)
            chk_mask[j] = 1'b1;
         else if ((4'(j) == idx_q) && (state_q == S_SETTLE))
            chk_mask[j] = 1'b1;
      end
      // Pick the lowest offending stage.
      for (int unsigned j = 0; j < STAGES; j++) begin
         if (!lost_any && chk_mask[j] && !stage_done[j]) begin
            lost_any = 1'b1;
            lost_idx = 4'(j);
         end
      end
      ack = |(stage_done & idx_oh);
   end

   // Next-state, counter and registered-output logic
   always_comb begin
      state_d = state_q;
      count_d = count_q + 32'd1;
      idx_d   = idx_q;
      en_d    = en_q;
      fs_d    = fs_q;
`ifdef STARTUP_SEQ_RETRY_EN
      retry_d = retry_q;
`endif

      if (restart) begin
         state_d = S_INIT;
         count_d = '0;
         idx_d   = '0;
         en_d    = '0;
         fs_d    = '0;
`ifdef STARTUP_SEQ_RETRY_EN
         retry_d = '0;
`endif
      end else begin
         unique case (state_q)
            S_INIT: begin
               if (count_q == INIT_TIME - 32'd1) begin
                  state_d = S_WAIT;
                  count_d = '0;
                  idx_d   = '0;
                  en_d    = STAGES'(1);
`ifdef STARTUP_SEQ_RETRY_EN
                  retry_d = '0;
`endif
               end
            end

            S_WAIT: begin
               if (lost_any) begin
                  state_d = S_FAULT;
                  count_d = '0;
                  en_d    = '0;
                  fs_d    = lost_idx;
               end else if (ack) begin
                  state_d = S_SETTLE;
                  count_d = '0;
               end else if (count_q == TIMEOUT - 32'd1) begin
                  count_d = '0;
`ifdef STARTUP_SEQ_RETRY_EN
                  if (retry_q < 4'(MAX_RETRIES)) begin
                     state_d = S_RETRY_OFF;
                     en_d    = en_q & ~idx_oh;
                  end else begin
                     state_d = S_FAULT;
                     en_d    = '0;
                     fs_d    = idx_q;
                  end
`else
                  state_d = S_FAULT;
                  en_d    = '0;
                  fs_d    = idx_q;
`endif
               end
            end

            S_SETTLE: begin
               if (lost_any) begin
                  state_d = S_FAULT;
                  count_d = '0;
                  en_d    = '0;
                  fs_d    = lost_idx;
               end else if (count_q == SETTLE_TIME - 32'd1) begin
                  count_d = '0;
                  if (idx_q == 4'(STAGES - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WAIT;
                     idx_d   = idx_q + 4'd1;
                     en_d    = en_q | next_oh;
`ifdef STARTUP_SEQ_RETRY_EN
                     retry_d = '0;
`endif
                  end
               end
            end

`ifdef STARTUP_SEQ_RETRY_EN
            S_RETRY_OFF: begin
               if (lost_any) begin
                  state_d = S_FAULT;
                  count_d = '0;
                  en_d    = '0;
                  fs_d    = lost_idx;
               end else if (count_q == SETTLE_TIME - 32'd1) begin
                  state_d = S_WAIT;
                  count_d = '0;
                  en_d    = en_q | idx_oh;
                  retry_d = retry_q + 4'd1;
               end
            end
`endif

            S_DONE: begin
               count_d = '0;
               if (lost_any) begin
                  state_d = S_FAULT;
                  en_d    = '0;
                  fs_d    = lost_idx;
               end
            end

            S_FAULT: begin
               count_d = '0;
            end

            default: begin
               state_d = S_INIT;
               count_d = '0;
               en_d    = '0;
            end
         endcase
      end

      // Status flags are decoded from the next state so they register
      // together with the state itself.
      busy_d = (state_d == S_INIT) || (state_d == S_WAIT) ||
               (state_d == S_SETTLE)
`ifdef STARTUP_SEQ_RETRY_EN
               || (state_d == S_RETRY_OFF)
`endif
               ;
      started_d = (state_d == S_DONE);
      fault_d   = (state_d == S_FAULT);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_INIT;
         count_q   <= '0;
         idx_q     <= '0;
         en_q      <= '0;
         busy_q    <= 1'b1;
         started_q <= 1'b0;
         fault_q   <= 1'b0;
         fs_q      <= '0;
`ifdef STARTUP_SEQ_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         started_q <= started_d;
         fault_q   <= fault_d;
         fs_q      <= fs_d;
`ifdef STARTUP_SEQ_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign stage_en    = en_q;
   assign busy        = busy_q;
   assign started     = started_q;
   assign fault       = fault_q;
   assign fault_stage = fs_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// -----------------------------------------------------------------------------
// tb_startup_sequencer
//
// Self-checking bench for startup_sequencer with STAGES=4, INIT_TIME=10,
// SETTLE_TIME=3, TIMEOUT=20 and MAX_RETRIES=2. Each vector holds its inputs for
// a number of clock edges. The outputs expected after the last of those edges
// are queued when the vector is driven, then popped and compared half a cycle
// after that edge. Edge numbers in the comments count from the start of the
// current sequence (reset release or the restart edge).
// -----------------------------------------------------------------------------
module tb_startup_sequencer;

   typedef struct {
      int         ncyc;
      logic       rs;
      logic [3:0] done;
      logic [3:0] en;
      logic       busy;
      logic       started;
      logic       fault;
      logic [3:0] fs;
   } vec_t;

   logic       clock;
   logic       reset_n;
   logic       restart;
   logic [3:0] stage_done;
   logic [3:0] stage_en;
   logic       busy;
   logic       started;
   logic       fault;
   logic [3:0] fault_stage;

   int checks = 0;
   int errors = 0;
   int vnum   = 0;

   vec_t tbl[$];
   vec_t sb[$];

   startup_sequencer #(
      .STAGES      (4),
      .INIT_TIME   (32'd10),
      .SETTLE_TIME (32'd3),
      .TIMEOUT     (32'd20),
      .MAX_RETRIES (2)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .restart     (restart),
      .stage_done  (stage_done),
      .stage_en    (stage_en),
      .busy        (busy),
      .started     (started),
      .fault       (fault),
      .fault_stage (fault_stage)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1);
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endfunction

   task automatic add(input int n, input logic rs, input logic [3:0] d,
                      input logic [3:0] en, input logic b, input logic s,
                      input logic f, input logic [3:0] fs);
      vec_t v;
      v.ncyc = n; v.rs = rs; v.done = d; v.en = en;
      v.busy = b; v.started = s; v.fault = f; v.fs = fs;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      restart    = v.rs;
      stage_done = v.done;
      sb.push_back(v);
      repeat (v.ncyc) @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      chk($sformatf("v%0d.stage_en", vnum), 32'(stage_en), 32'(e.en));
      chk($sformatf("v%0d.busy", vnum), 32'(busy), 32'(e.busy));
      chk($sformatf("v%0d.started", vnum), 32'(started), 32'(e.started));
      chk($sformatf("v%0d.fault", vnum), 32'(fault), 32'(e.fault));
      if (e.fault)
         chk($sformatf("v%0d.fault_stage", vnum), 32'(fault_stage), 32'(e.fs));
      vnum++;
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      tbl.delete();
   endtask

   // INIT: stage_en[0] rises on the 10th edge.
   task automatic add_init();
      add(9, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
      add(1, 0, 4'b0000, 4'b0001, 1, 0, 0, 0);   // edge 10
   endtask

   // Stage 0 acknowledges on edge 12, so stage_en[1] rises on edge 15.
   task automatic add_stage0();
      add(1, 0, 4'b0000, 4'b0001, 1, 0, 0, 0);   // 11
      add(1, 0, 4'b0001, 4'b0001, 1, 0, 0, 0);   // 12 ack -> SETTLE
      add(2, 0, 4'b0001, 4'b0001, 1, 0, 0, 0);   // 14
      add(1, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);   // 15
   endtask

   // Stages 1..3 each acknowledge on the second edge after their enable.
   task automatic add_rest();
      add(1, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);   // 16
      add(1, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 17 ack
      add(2, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 19
      add(1, 0, 4'b0011, 4'b0111, 1, 0, 0, 0);   // 20
      add(1, 0, 4'b0011, 4'b0111, 1, 0, 0, 0);   // 21
      add(1, 0, 4'b0111, 4'b0111, 1, 0, 0, 0);   // 22 ack
      add(2, 0, 4'b0111, 4'b0111, 1, 0, 0, 0);   // 24
      add(1, 0, 4'b0111, 4'b1111, 1, 0, 0, 0);   // 25
      add(1, 0, 4'b0111, 4'b1111, 1, 0, 0, 0);   // 26
      add(1, 0, 4'b1111, 4'b1111, 1, 0, 0, 0);   // 27 ack
      add(2, 0, 4'b1111, 4'b1111, 1, 0, 0, 0);   // 29
      add(1, 0, 4'b1111, 4'b1111, 0, 1, 0, 0);   // 30 DONE
   endtask

   task automatic add_restart();
      add(1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
   endtask

`ifdef STARTUP_SEQ_RETRY_EN
   // Stage 1 stays silent: timeouts on edges 35 and 58, each followed by a
   // 3-cycle low pulse on stage_en[1].
   task automatic add_two_retries();
      add(19, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 34
      add(1,  0, 4'b0001, 4'b0001, 1, 0, 0, 0);  // 35 RETRY_OFF
      add(2,  0, 4'b0001, 4'b0001, 1, 0, 0, 0);  // 37
      add(1,  0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 38 re-enabled
      add(19, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 57
      add(1,  0, 4'b0001, 4'b0001, 1, 0, 0, 0);  // 58 RETRY_OFF
      add(2,  0, 4'b0001, 4'b0001, 1, 0, 0, 0);  // 60
      add(1,  0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 61 re-enabled
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      restart    = 1'b0;
      stage_done = 4'b0000;

      // Reset values, including across an edge while reset is held.
      #12;
      chk("rst.stage_en", 32'(stage_en), 32'h0);
      chk("rst.busy", 32'(busy), 32'h1);
      chk("rst.started", 32'(started), 32'h0);
      chk("rst.fault", 32'(fault), 32'h0);
      chk("rst.fault_stage", 32'(fault_stage), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // Nominal bring-up, then loss of acknowledge in DONE on stages 3 and 1.
      add_init();
      add_stage0();
      add_rest();
      add(1, 0, 4'b1111, 4'b1111, 0, 1, 0, 0);   // 31 DONE holds
      add(1, 0, 4'b0101, 4'b0000, 0, 0, 1, 1);   // 32 FAULT, lowest = 1
      add(3, 0, 4'b0101, 4'b0000, 0, 0, 1, 1);
      add(2, 0, 4'b1111, 4'b0000, 0, 0, 1, 1);   // FAULT latches
      // Restart from FAULT; the full sequence repeats.
      add_restart();
      add_init();
      add_stage0();
      // Restart in the middle of stage 1 SETTLE.
      add(1, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);   // 16
      add(1, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 17 ack -> SETTLE
      add(1, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 18
      add(1, 1, 4'b0011, 4'b0000, 1, 0, 0, 0);   // restart
      add_init();
      add_stage0();
      add_rest();
      add_restart();
      add_init();
      add_stage0();
`ifdef STARTUP_SEQ_RETRY_EN
      // Stage 1 acknowledges on its third enable.
      add_two_retries();
      add(1, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);   // 62
      add(1, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 63 ack
      add(2, 0, 4'b0011, 4'b0011, 1, 0, 0, 0);   // 65
      add(1, 0, 4'b0011, 4'b0111, 1, 0, 0, 0);   // 66
      add(1, 0, 4'b0011, 4'b0111, 1, 0, 0, 0);   // 67
      add(1, 0, 4'b0111, 4'b0111, 1, 0, 0, 0);   // 68 ack
      add(2, 0, 4'b0111, 4'b0111, 1, 0, 0, 0);   // 70
      add(1, 0, 4'b0111, 4'b1111, 1, 0, 0, 0);   // 71
      add(1, 0, 4'b0111, 4'b1111, 1, 0, 0, 0);   // 72
      add(1, 0, 4'b1111, 4'b1111, 1, 0, 0, 0);   // 73 ack
      add(2, 0, 4'b1111, 4'b1111, 1, 0, 0, 0);   // 75
      add(1, 0, 4'b1111, 4'b1111, 0, 1, 0, 0);   // 76 DONE
      // Stage 1 never acknowledges: the third timeout faults.
      add_restart();
      add_init();
      add_stage0();
      add_two_retries();
      add(19, 0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 80
      add(1,  0, 4'b0001, 4'b0000, 0, 0, 1, 1);  // 81 FAULT
`else
      // Stage 2 never acknowledges: FAULT 20 edges after stage_en[2] rises.
      add(1,  0, 4'b0001, 4'b0011, 1, 0, 0, 0);  // 16
      add(1,  0, 4'b0011, 4'b0011, 1, 0, 0, 0);  // 17 ack
      add(2,  0, 4'b0011, 4'b0011, 1, 0, 0, 0);  // 19
      add(1,  0, 4'b0011, 4'b0111, 1, 0, 0, 0);  // 20
      add(19, 0, 4'b0011, 4'b0111, 1, 0, 0, 0);  // 39
      add(1,  0, 4'b0011, 4'b0000, 0, 0, 1, 2);  // 40 FAULT
      add(2,  0, 4'b0011, 4'b0000, 0, 0, 1, 2);
`endif
      // Bring the block back to mid-sequence for the reset test.
      add_restart();
      add_init();
      add_stage0();
      run_table();

      // Asynchronous reset pulse between edges: outputs clear at once.
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.stage_en", 32'(stage_en), 32'h0);
      chk("arst.busy", 32'(busy), 32'h1);
      chk("arst.started", 32'(started), 32'h0);
      chk("arst.fault", 32'(fault), 32'h0);
      chk("arst.fault_stage", 32'(fault_stage), 32'h0);
      stage_done = 4'b0000;
      @(negedge clock);
      chk("arst_hold.stage_en", 32'(stage_en), 32'h0);
      reset_n = 1'b1;

      // stage_en[0] rises 10 edges after release; full bring-up follows.
      add_init();
      add_stage0();
      add_rest();
      run_table();

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/startup_sequencer.md
# startup_sequencer

Power-up sequencer that brings up to 16 dependent stages (PLLs, memory PHYs, codecs) in order after a fixed startup delay. Each stage is enabled, must acknowledge within a timeout, then gets a settle interval before the next stage is enabled. After bring-up the block supervises the stages, and any later loss of an acknowledge shuts everything down. It sits between the board reset and the subsystems that need ordered bring-up, and provides a single `started` qualifier to downstream logic.

## Interface
- `STAGES`, 4: number of sequenced stages, 1..16.
- `INIT_TIME`, 32'd100000000: cycles spent in INIT before stage 0 is enabled (0.5 s at 200 MHz); must be ≥1.
- `SETTLE_TIME`, 32'd1000: cycles after a stage acknowledges before the next stage is enabled. Also used as the off-time during a retry. Must be ≥1.
- `TIMEOUT`, 32'd2000000: cycles a stage has to acknowledge; must be ≥1.
- `MAX_RETRIES`, 2: retries per stage (used only with `STARTUP_SEQ_RETRY_EN`), 0..15.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous request to rerun the full sequence from INIT.
- `stage_done`  in  STAGES  per-stage acknowledge; must already be synchronous to `clock`.
- `stage_en`  out  STAGES  per-stage enable; cumulative, so lower bits stay high.
- `busy`  out  1  high in INIT, WAIT, SETTLE and RETRY_OFF.
- `started`  out  1  high only in DONE.
- `fault`  out  1  high only in FAULT.
- `fault_stage`  out  4  index of the stage that caused the fault; valid while `fault` is high.

## Operation
- All outputs are registered.
- Counter rules:
  - One 32-bit counter is cleared on every state entry.
  - It increments once per cycle in timed states.
  - Each timed state exits when `count == LIMIT-1`, so a state lasts exactly LIMIT cycles.
- Stage index `idx` is 4 bits wide. The retry counter is 4 bits wide.
- **INIT:** `stage_en`=0. After INIT_TIME cycles: `idx`=0, set `stage_en[0]`, go to WAIT.
- **WAIT:**
  - If `stage_done[idx]` is sampled high: go to SETTLE.
  - Else, at TIMEOUT cycles: go to FAULT with `fault_stage`=`idx` (or start a retry, see Configuration).
- **SETTLE:** after SETTLE_TIME cycles:
  - If `idx`==STAGES-1: go to DONE.
  - Else: `idx`+1, set `stage_en[idx+1]`, clear the retry counter, go to WAIT.
- Loss of acknowledge before DONE:
  - Applies in WAIT and SETTLE, to any stage j<`idx` whose `stage_done[j]` is sampled low.
  - In SETTLE it also applies to j=`idx`.
  - Response: go to FAULT with `fault_stage` = lowest such j.
- **DONE:** `started`=1. Any `stage_done` bit sampled low → FAULT with `fault_stage` = lowest low bit.
- **FAULT:** `stage_en`=0, `fault`=1. Holds until `restart` or reset.
- `restart` from any state: next state is INIT, counter=0, `stage_en`=0, `fault`=0, `started`=0.

## Timing
- Reset values: `stage_en`=0, `busy`=1, `started`=0, `fault`=0, `fault_stage`=0, state INIT, counter 0.
- `reset_n` low acts immediately, without waiting for a clock edge.
- With `reset_n` released before edge 1, `stage_en[0]` goes high on edge INIT_TIME.
- Acknowledge sampled on edge k in WAIT: SETTLE begins at edge k. The next `stage_en` bit goes high on edge k+SETTLE_TIME.
- Best-case total bring-up: `started` rises on edge INIT_TIME + STAGES·(1+SETTLE_TIME).
- Timeout: FAULT is entered on the TIMEOUT-th edge of WAIT.
- Simultaneous events, in priority order:
  1. `restart`.
  2. Loss of acknowledge.
  3. `stage_done[idx]`.
  4. Timeout.
  5. Counter expiry.
- Acknowledge and timeout on the same edge: the acknowledge wins.
- Re-entry into INIT after `restart` is one cycle; outputs change on that edge.

## Configuration
- `STARTUP_SEQ_RETRY_EN` **defined:** a timeout in WAIT is handled as a retry while the retry counter is below MAX_RETRIES:
  - Clear `stage_en[idx]` and go to RETRY_OFF.
  - Stay in RETRY_OFF for SETTLE_TIME cycles. Loss-of-acknowledge checks on stages below `idx` still apply.
  - Then set `stage_en[idx]` again, increment the retry counter, and return to WAIT.
  - Once MAX_RETRIES retries are used up, the next timeout goes to FAULT.
- `STARTUP_SEQ_RETRY_EN` **undefined:** the RETRY_OFF state and the retry counter are not built, and a timeout goes straight to FAULT.

## Test plan
- **Nominal bring-up.** INIT_TIME=10, SETTLE_TIME=3, STAGES=4, each `stage_done` raised 2 cycles after its enable → enables rise in order. `started` rises at the predicted edge, `busy` falls.
- **Timeout, retries compiled out.** Stage 2 never acknowledges, TIMEOUT=20 → FAULT 20 cycles after `stage_en[2]` rises, `fault_stage`=2, `stage_en`=0.
- **Timeout with `STARTUP_SEQ_RETRY_EN`.** MAX_RETRIES=2:
  - Stage 1 acknowledges on its 3rd enable → two SETTLE_TIME-long low pulses on `stage_en[1]`, then normal completion.
  - Stage 1 never acknowledges → FAULT after the 3rd timeout.
- **Loss of acknowledge in DONE.** Drop `stage_done[3]` and `stage_done[1]` together → FAULT next edge, `fault_stage`=1.
- **Restart.** Assert `restart` mid-SETTLE and in FAULT → INIT next edge, `stage_en`=0, `fault`=0, full sequence repeats.
- **Reset mid-sequence.** Async `reset_n` pulse between edges → outputs at reset values immediately. `stage_en[0]` rises INIT_TIME edges after release.
